// File: rtl/square_iter_pkg.sv
// Shared definitions for the square_iter block: FSM state encoding and default root width.
// The same encoding and width are used by sqrt_lut and the benches.
package square_iter_pkg;

    localparam int SQ_IN_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter width for a step count of w; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/square_iter_if.sv
// Valid/ready stream bundle around square_iter: operand side (sq_in/val_i/rdy_o)
// and result side (sq_out/val_o/rdy_i).
interface square_iter_if
    import square_iter_pkg::*;
#(
    parameter int IN_W = SQ_IN_W
) ();

    logic [IN_W-1:0]   sq_in;
    logic              val_i;
    logic              rdy_o;
    logic [2*IN_W-1:0] sq_out;
    logic              val_o;
    logic              rdy_i;

    modport slave (
        input  sq_in,
        input  val_i,
        output rdy_o,
        output sq_out,
        output val_o,
        input  rdy_i
    );

    modport master (
        output sq_in,
        output val_i,
        input  rdy_o,
        input  sq_out,
        input  val_o,
        output rdy_i
    );

endinterface

// File: rtl/square_iter.sv
// Exact square of an unsigned root using a one-bit-per-cycle shift-add multiplier,
// with valid/ready handshakes on both the operand and the result side.
module square_iter
    import square_iter_pkg::*;
#(
    parameter int IN_W = SQ_IN_W
) (
    input  logic          clk,
    input  logic          rst_n,
    square_iter_if.slave  bus
);

    localparam int OUT_W = 2 * IN_W;
    localparam int CNT_W = cnt_width(IN_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_W - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [OUT_W-1:0] r_mcand;
    logic [OUT_W-1:0] r_acc;
    logic [OUT_W-1:0] r_sq_out;
    logic [IN_W-1:0]  r_mplier;
    logic [CNT_W-1:0] r_cnt;
    logic             r_val_o;

    logic [OUT_W-1:0] w_acc_sum;
    logic             w_accept;
    logic             w_last;
    logic             w_handshake;
    logic             w_rdy_o;

    assign w_accept    = (r_state == ST_IDLE) && bus.val_i;
    assign w_last      = (r_state == ST_CALC) && (r_cnt == CNT_LAST);
    assign w_handshake = (r_state == ST_DONE) && bus.rdy_i;
    // The final step's partial product must be folded in before sq_out is captured.
    assign w_acc_sum   = r_acc + (r_mplier[0] ? r_mcand : '0);

    assign bus.rdy_o  = w_rdy_o;
    assign bus.sq_out = r_sq_out;
    assign bus.val_o  = r_val_o;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_rdy_o      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_rdy_o = 1'b1;
                if (w_accept) begin
                    w_state_next = ST_CALC;
                end
            end
            ST_CALC: begin
                if (w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (w_handshake) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_sq_out <= '0;
            r_val_o  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_mcand  <= {{IN_W{1'b0}}, bus.sq_in};
                r_mplier <= bus.sq_in;
                r_acc    <= '0;
                r_cnt    <= '0;
            end
            if (r_state == ST_CALC) begin
                r_acc    <= w_acc_sum;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + 1'b1;
                if (w_last) begin
                    r_sq_out <= w_acc_sum;
                    r_val_o  <= 1'b1;
                end
            end
            if (w_handshake) begin
                r_val_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_square_iter.sv
// Directed bench for square_iter: reset, single squares, back-pressure,
// reset during calculation and a continuous valid/ready stream.
module tb_square_iter;
    import square_iter_pkg::*;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    square_iter_if #(.IN_W(8)) bus ();

    square_iter #(.IN_W(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        tests_run++;
        if (bus.rdy_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_rdy_o: got %b expected 1", bus.rdy_o);
        end
        tests_run++;
        if (bus.val_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_val_o: got %b expected 0", bus.val_o);
        end
        tests_run++;
        if (bus.sq_out !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_sq_out: got %h expected 0000", bus.sq_out);
        end
        rst_n = 1'b1;
        step();
        tests_run++;
        if (bus.rdy_o !== 1'b1 || bus.val_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release: rdy_o=%b val_o=%b expected 1/0", bus.rdy_o, bus.val_o);
        end
        $display("[TB] reset checked");
    endtask

    // One operand through with rdy_i held high; checks latency, value and return to idle.
    task automatic test_vector(input string name, input logic [7:0] x, input logic [15:0] exp);
        int lat;
        bit got;
        bus.rdy_i = 1'b1;
        tests_run++;
        if (bus.rdy_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s_rdy_before: got %b expected 1", name, bus.rdy_o);
        end
        bus.sq_in = x;
        bus.val_i = 1'b1;
        step();
        bus.val_i = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            step();
            lat++;
            if (bus.val_o === 1'b1) got = 1'b1;
        end
        tests_run++;
        if (!got || lat != 8) begin
            tests_failed++;
            $display("FAIL %s_latency: got %0d cycles (seen=%b) expected 8", name, lat, got);
        end
        tests_run++;
        if (bus.sq_out !== exp) begin
            tests_failed++;
            $display("FAIL %s_value: got %h expected %h", name, bus.sq_out, exp);
        end
        tests_run++;
        if (bus.rdy_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_rdy_done: got %b expected 0", name, bus.rdy_o);
        end
        step();
        tests_run++;
        if (bus.val_o !== 1'b0 || bus.rdy_o !== 1'b1 || bus.sq_out !== exp) begin
            tests_failed++;
            $display("FAIL %s_after_xfer: val_o=%b rdy_o=%b sq_out=%h expected 0/1/%h",
                     name, bus.val_o, bus.rdy_o, bus.sq_out, exp);
        end
        $display("[TB] %s: sq_in=%h sq_out=%h latency=%0d", name, x, bus.sq_out, lat);
    endtask

    task automatic test_backpressure();
        int lat;
        bit got;
        bit seen;
        bus.rdy_i = 1'b0;
        bus.sq_in = 8'h80;
        bus.val_i = 1'b1;
        step();
        bus.val_i = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            step();
            lat++;
            if (bus.val_o === 1'b1) got = 1'b1;
        end
        tests_run++;
        if (!got || lat != 8) begin
            tests_failed++;
            $display("FAIL bp_latency: got %0d cycles (seen=%b) expected 8", lat, got);
        end
        for (int i = 0; i < 20; i++) begin
            bus.val_i = i[0];
            bus.sq_in = 8'h55;
            step();
            tests_run++;
            if (bus.val_o !== 1'b1 || bus.sq_out !== 16'h4000 || bus.rdy_o !== 1'b0) begin
                tests_failed++;
                $display("FAIL bp_hold_%0d: val_o=%b sq_out=%h rdy_o=%b expected 1/4000/0",
                         i, bus.val_o, bus.sq_out, bus.rdy_o);
            end
        end
        bus.val_i = 1'b0;
        bus.rdy_i = 1'b1;
        step();
        tests_run++;
        if (bus.val_o !== 1'b0 || bus.rdy_o !== 1'b1 || bus.sq_out !== 16'h4000) begin
            tests_failed++;
            $display("FAIL bp_xfer: val_o=%b rdy_o=%b sq_out=%h expected 0/1/4000",
                     bus.val_o, bus.rdy_o, bus.sq_out);
        end
        seen = 1'b0;
        repeat (12) begin
            step();
            if (bus.val_o === 1'b1) seen = 1'b1;
        end
        tests_run++;
        if (seen) begin
            tests_failed++;
            $display("FAIL bp_single_xfer: got extra val_o expected none");
        end
        $display("[TB] backpressure: sq_in=80 held 20 cycles, sq_out=%h", bus.sq_out);
    endtask

    task automatic test_reset_mid_calc();
        bit seen;
        bus.rdy_i = 1'b1;
        bus.sq_in = 8'hC3;
        bus.val_i = 1'b1;
        step();
        bus.val_i = 1'b0;
        repeat (4) step();
        rst_n = 1'b0;
        step();
        tests_run++;
        if (bus.rdy_o !== 1'b1 || bus.val_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_state: rdy_o=%b val_o=%b expected 1/0", bus.rdy_o, bus.val_o);
        end
        tests_run++;
        if (bus.sq_out !== 16'h0000) begin
            tests_failed++;
            $display("FAIL midrst_sq_out: got %h expected 0000", bus.sq_out);
        end
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            step();
            if (bus.val_o === 1'b1 || bus.rdy_o !== 1'b1) seen = 1'b1;
        end
        tests_run++;
        if (seen) begin
            tests_failed++;
            $display("FAIL midrst_stale: got stale output or busy state expected idle");
        end
        $display("[TB] reset mid-calc: sq_in=C3 discarded");
    endtask

    task automatic test_back_to_back();
        logic [7:0]  q[$];
        logic [7:0]  exp_x;
        logic [15:0] exp_sq;
        int  accepts, results, last_acc, k;
        bit  acc, res;
        logic [15:0] res_val;
        accepts  = 0;
        results  = 0;
        last_acc = -1;
        k        = 0;
        bus.rdy_i = 1'b1;
        bus.sq_in = 8'(k * 53 + 7);
        bus.val_i = 1'b1;
        for (int cyc = 0; cyc < 120; cyc++) begin
            if (cyc == 100) bus.val_i = 1'b0;
            acc     = (bus.val_i === 1'b1) && (bus.rdy_o === 1'b1);
            res     = (bus.val_o === 1'b1);
            res_val = bus.sq_out;
            step();
            if (res) begin
                tests_run++;
                if (q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL b2b_dup: got result %h with no pending operand", res_val);
                end else begin
                    exp_x  = q.pop_front();
                    exp_sq = 16'(exp_x) * 16'(exp_x);
                    if (res_val !== exp_sq) begin
                        tests_failed++;
                        $display("FAIL b2b_result_%0d: got %h expected %h", results, res_val, exp_sq);
                    end
                end
                $display("[TB] b2b result %0d: sq_out=%h", results, res_val);
                results++;
            end
            if (acc) begin
                q.push_back(bus.sq_in);
                if (last_acc >= 0) begin
                    tests_run++;
                    if (cyc - last_acc != 10) begin
                        tests_failed++;
                        $display("FAIL b2b_interval: got %0d cycles expected 10", cyc - last_acc);
                    end
                end
                $display("[TB] b2b accept %0d: sq_in=%h at cycle %0d", accepts, bus.sq_in, cyc);
                last_acc = cyc;
                accepts++;
                k++;
                bus.sq_in = 8'(k * 53 + 7);
            end
        end
        tests_run++;
        if (accepts != 10 || results != 10 || q.size() != 0) begin
            tests_failed++;
            $display("FAIL b2b_counts: accepts=%0d results=%0d pending=%0d expected 10/10/0",
                     accepts, results, q.size());
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        bus.sq_in    = '0;
        bus.val_i    = 1'b0;
        bus.rdy_i    = 1'b1;

        test_reset();
        test_vector("zero", 8'h00, 16'h0000);
        test_vector("ff",   8'hFF, 16'hFE01);
        test_vector("x10",  8'h10, 16'h0100);
        test_vector("x0b",  8'h0B, 16'h0079);
        test_vector("x01",  8'h01, 16'h0001);
        test_vector("xaa",  8'hAA, 16'h70E4);
        test_backpressure();
        test_reset_mid_calc();
        test_vector("c3_after_rst", 8'hC3, 16'h9489);
        test_back_to_back();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
